alu_flag_commit: RTL and testbench

- Downstream stage of the 32-bit add/sub datapath (ADD/ADCS/SUBS/RSBS).
- Accepts each adder result with its N/Z/C/V flags and an ARM-style condition code, then evaluates the condition against the architectural NZCV register.
- Updates NZCV when the op executes and requests set-flags, and buffers the committed result in a small in-order FIFO toward writeback.
- Drives the committed carry back upstream as the adder's c_in for ADCS chaining.

---
 rtl/alu_flag_commit.sv | 184 ++++++++++++++++++
 tb/tb_alu_flag_commit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_commit.sv
// Flag commit stage: evaluates the condition code against NZCV, updates the flags, and queues committed results.
// Latency: 1 cycle from accept to out_valid. There is no bypass around the result FIFO.
// Backpressure: in_ready depends only on the registered FIFO count, so out_ready has no combinational path to in_ready.

// Generic in-order FIFO with valid/ready handshakes on both sides.
// Latency: 1 cycle from push to pop_vld. Push and pop can happen in the same cycle.
// Backpressure: push_rdy comes from the registered count only. It drops at DEPTH entries.
module alu_flag_commit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign push_rdy = (count < DEPTH_C);
    assign pop_vld  = (count != '0);
    assign push     = push_vld & push_rdy;
    assign pop      = pop_vld & pop_rdy;
    assign pop_dat  = mem[rd_ptr];

    // Storage is not reset. Stale contents are never visible because the consumer gates on pop_vld.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module alu_flag_commit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_s,
    input  logic        in_n,
    input  logic        in_z,
    input  logic        in_c,
    input  logic        in_v,
    input  logic        in_setflags,
    input  logic [3:0]  in_cond,
    input  logic        flags_we,
    input  logic [3:0]  flags_wdata,
    output logic [3:0]  flags_nzcv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_nzcv,
    output logic        out_executed
);
    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  nzcv;
        logic        executed;
    } entry_t;

    logic   accept;
    logic   cond_pass;
    logic   set_from_op;
    logic [3:0] flags_next;
    entry_t push_entry;
    entry_t head_entry;
    logic   fifo_vld;

    // ARM condition table. Operand flags are packed as {N,Z,C,V}.
    function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'd0:    r = z;
            4'd1:    r = !z;
            4'd2:    r = c;
            4'd3:    r = !c;
            4'd4:    r = n;
            4'd5:    r = !n;
            4'd6:    r = v;
            4'd7:    r = !v;
            4'd8:    r = c & !z;
            4'd9:    r = !c | z;
            4'd10:   r = (n == v);
            4'd11:   r = (n != v);
            4'd12:   r = !z & (n == v);
            4'd13:   r = z | (n != v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    assign accept      = in_valid & in_ready;
    assign cond_pass   = eval_cond(in_cond, flags_nzcv);
    assign set_from_op = accept & cond_pass & in_setflags;

    // Next NZCV value. A flag-setting op that executes takes priority and drops the direct write.
    always_comb begin
        flags_next = flags_nzcv;
        if (set_from_op) begin
            flags_next = {in_n, in_z, in_c, in_v};
        end else if (flags_we) begin
            flags_next = flags_wdata;
        end
    end

    // Architectural NZCV register. Bit 1 (C) is the carry-in for ADCS chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_nzcv <= 4'b0000;
        end else begin
            flags_nzcv <= flags_next;
        end
    end

    // Each entry carries the post-edge flags so the consumer sees the NZCV value this op left behind.
    always_comb begin
        push_entry          = '0;
        push_entry.result   = in_s;
        push_entry.nzcv     = flags_next;
        push_entry.executed = cond_pass;
    end

    alu_flag_commit_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (push_entry),
        .pop_vld  (fifo_vld),
        .pop_rdy  (out_ready),
        .pop_dat  (head_entry)
    );

    // Zero the head fields while the FIFO is empty so stale storage never reaches the outputs.
    always_comb begin
        out_valid    = fifo_vld;
        out_result   = fifo_vld ? head_entry.result   : 32'd0;
        out_nzcv     = fifo_vld ? head_entry.nzcv     : 4'd0;
        out_executed = fifo_vld ? head_entry.executed : 1'b0;
    end
endmodule

// File: tb/tb_alu_flag_commit.sv
module tb_alu_flag_commit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_s;
    logic        in_n, in_z, in_c, in_v;
    logic        in_setflags;
    logic [3:0]  in_cond;
    logic        flags_we;
    logic [3:0]  flags_wdata;
    logic [3:0]  flags_nzcv;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_nzcv;
    logic        out_executed;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        logic        e;
    } exp_t;

    exp_t       q[$];
    logic [3:0] mflags;

    alu_flag_commit #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_s         (in_s),
        .in_n         (in_n),
        .in_z         (in_z),
        .in_c         (in_c),
        .in_v         (in_v),
        .in_setflags  (in_setflags),
        .in_cond      (in_cond),
        .flags_we     (flags_we),
        .flags_wdata  (flags_wdata),
        .flags_nzcv   (flags_nzcv),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_nzcv     (out_nzcv),
        .out_executed (out_executed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of the condition check. Even codes test a base predicate and the paired odd code is its inverse. Code 15 is always true.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[0] && c != 4'hF) r = !r;
        return r;
    endfunction

    // Update the model for the coming edge, using the state it holds before that edge.
    task automatic model_edge();
        logic acc, pop, p;
        logic [3:0] nf;
        acc = in_valid && (q.size() < DEPTH);
        pop = (q.size() > 0) && out_ready;
        p   = cond_ok(in_cond, mflags);
        nf  = mflags;
        if (acc && p && in_setflags) nf = {in_n, in_z, in_c, in_v};
        else if (flags_we)           nf = flags_wdata;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back('{r: in_s, f: nf, e: p});
        mflags = nf;
    endtask

    task automatic check_all();
        check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("flags_nzcv", 64'(flags_nzcv), 64'(mflags));
        if (q.size() > 0) begin
            check("out_result", 64'(out_result), 64'(q[0].r));
            check("out_nzcv", 64'(out_nzcv), 64'(q[0].f));
            check("out_executed", 64'(out_executed), 64'(q[0].e));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] s, input logic [3:0] nzcv,
                         input logic sf, input logic [3:0] cond, input logic ordy);
        in_valid = v; in_s = s;
        {in_n, in_z, in_c, in_v} = nzcv;
        in_setflags = sf; in_cond = cond; out_ready = ordy;
        flags_we = 1'b0; flags_wdata = 4'h0;
    endtask

    task automatic drain();
        drive(1'b0, 32'd0, 4'h0, 1'b0, 4'hE, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) tick();
    endtask

    initial begin
        mflags = 4'h0;
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 4'h0, 1'b0, 4'hE, 1'b0);
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_nzcv", 64'(out_nzcv), 64'd0);
        check("rst_out_executed", 64'(out_executed), 64'd0);
        check("rst_flags", 64'(flags_nzcv), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // SUBS result zero with carry, AL, setflags
        drive(1'b1, 32'd0, 4'b0110, 1'b1, 4'hE, 1'b0);
        tick();
        check("subs_valid", 64'(out_valid), 64'd1);
        check("subs_nzcv", 64'(out_nzcv), 64'b0110);
        check("subs_exec", 64'(out_executed), 64'd1);
        check("subs_flags", 64'(flags_nzcv), 64'b0110);
        drain();

        // NE fails with Z=1: the result is still delivered but the flags are kept
        drive(1'b1, 32'd5, 4'b0000, 1'b1, 4'h1, 1'b0);
        tick();
        check("ne_exec", 64'(out_executed), 64'd0);
        check("ne_result", 64'(out_result), 64'd5);
        check("ne_flags", 64'(flags_nzcv), 64'b0110);
        drain();

        // Back-to-back: the carry set by op1 is seen by op2 (CS)
        drive(1'b1, 32'd7, 4'b0010, 1'b1, 4'hE, 1'b1);
        tick();
        check("b2b_c1", 64'(flags_nzcv[1]), 64'd1);
        drive(1'b1, 32'd8, 4'b0000, 1'b0, 4'h2, 1'b1);
        tick();
        check("b2b_exec", 64'(out_executed), 64'd1);
        check("b2b_result", 64'(out_result), 64'd8);
        check("b2b_c2", 64'(flags_nzcv[1]), 64'd1);
        drain();

        // Full FIFO backpressure and ordering
        drive(1'b1, 32'd1, 4'h0, 1'b0, 4'hE, 1'b0); tick();
        drive(1'b1, 32'd2, 4'h0, 1'b0, 4'hE, 1'b0); tick();
        check("full_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'd3, 4'h0, 1'b0, 4'hE, 1'b0); tick();
        check("full_head1", 64'(out_result), 64'd1);
        out_ready = 1'b1; tick();
        check("full_head2", 64'(out_result), 64'd2);
        tick();
        check("full_head3", 64'(out_result), 64'd3);
        drain();

        // An executed setflags op beats the same-cycle direct write
        drive(1'b1, 32'd9, 4'b0100, 1'b1, 4'hE, 1'b1);
        flags_we = 1'b1; flags_wdata = 4'b1001;
        tick();
        check("prio_flags", 64'(flags_nzcv), 64'b0100);
        drive(1'b0, 32'd0, 4'h0, 1'b0, 4'hE, 1'b1);
        flags_we = 1'b1; flags_wdata = 4'b1001;
        tick();
        check("we_flags", 64'(flags_nzcv), 64'b1001);
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_s        = $urandom;
            {in_n, in_z, in_c, in_v} = 4'($urandom);
            in_setflags = $urandom_range(0, 1) == 1;
            in_cond     = 4'($urandom);
            out_ready   = ($urandom_range(0, 2) != 0);
            flags_we    = ($urandom_range(0, 7) == 0);
            flags_wdata = 4'($urandom);
            tick();
        end

        // Reset in the middle of traffic with two entries queued
        drive(1'b1, 32'd11, 4'b1000, 1'b1, 4'hE, 1'b0); tick();
        drive(1'b1, 32'd12, 4'b0001, 1'b1, 4'hE, 1'b0); tick();
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_flags", 64'(flags_nzcv), 64'd0);
        q.delete();
        mflags = 4'h0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
